gcd_lcm_coproc: RTL and testbench

//  Responder side of the CPU-to-coprocessor command interface: accepts a GCD/LCM

---
 rtl/coproc_pkg.sv | 10 +
 rtl/gcd_lcm_coproc_if.sv | 18 +
 rtl/coproc_divu.sv | 38 +++
 rtl/gcd_lcm_coproc.sv | 140 ++++++++++++++
 tb/tb_gcd_lcm_coproc.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/coproc_pkg.sv
// coproc_pkg: shared opcode/state types and counter sizing for the GCD/LCM coprocessor
package coproc_pkg;
    typedef enum logic {OP_GCD = 1'b0, OP_LCM = 1'b1} op_e;
    typedef enum logic [2:0] {IDLE, GCD_SHIFT, GCD_RUN, DIV, MUL, DONE} state_e;
    localparam int DEF_WIDTH = 32;
    localparam int K_W = $clog2(DEF_WIDTH) + 1;
    function automatic int kw(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/gcd_lcm_coproc_if.sv
// gcd_lcm_coproc_if: request/response handshake between CPU controller (master) and coprocessor (slave)
interface gcd_lcm_coproc_if #(parameter int WIDTH = 32);
    import coproc_pkg::*;
    logic             req_valid;
    logic             req_ready;
    op_e              req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;
    logic             busy;
    modport master (output req_valid, req_op, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_result, rsp_err, busy);
    modport slave  (input  req_valid, req_op, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_result, rsp_err, busy);
endinterface

// File: rtl/coproc_divu.sv
// coproc_divu: restoring shift-subtract unsigned divider, fixed WIDTH-cycle latency after start.
// done is high during the last iteration cycle; quotient is final on the following cycle.
module coproc_divu #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   rs, df;
    logic             ge;
    always_comb begin
        rs = {rem, quotient[WIDTH-1]};
        df = rs - {1'b0, divisor};
        ge = rs >= {1'b0, divisor};
    end
    assign done = cnt == CW'(1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            rem      <= '0;
            quotient <= '0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            rem      <= '0;
            quotient <= dividend;
        end else if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            rem      <= ge ? df[WIDTH-1:0] : rs[WIDTH-1:0];
            quotient <= {quotient[WIDTH-2:0], ge};
        end
    end
endmodule

// File: rtl/gcd_lcm_coproc.sv
// gcd_lcm_coproc: iterative binary-GCD / LCM responder on a valid/ready command interface.
// Define COPROC_LCM_EN to build the divider and multiplier; otherwise LCM requests return err.
module gcd_lcm_coproc
    import coproc_pkg::*;
#(parameter int WIDTH = 32) (
    input logic             clk,
    input logic             reset_n,
    gcd_lcm_coproc_if.slave bus
);
    localparam int KW = kw(WIDTH);
    state_e           state, state_n;
    logic [WIDTH-1:0] a, a_n, b, b_n, res, res_n, g;
    logic [KW-1:0]    k, k_n;
    logic             err, err_n;
`ifdef COPROC_LCM_EN
    op_e                op, op_n;
    logic [WIDTH-1:0]   ao, ao_n, bo, bo_n, div_q;
    logic [2*WIDTH-1:0] acc, acc_n, prod;
    logic [KW-1:0]      mc, mc_n;
    logic               div_start, div_done;
    coproc_divu #(.WIDTH(WIDTH)) u_divu (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (ao),
        .divisor  (g),
        .done     (div_done),
        .quotient (div_q)
    );
    // one partial product per cycle, quotient bit mc selects B shifted into place
    assign prod = acc + (div_q[mc[KW-2:0]] ? ({{WIDTH{1'b0}}, bo} << mc) : '0);
`endif
    assign g              = a << k;
    assign bus.req_ready  = state == IDLE;
    assign bus.busy       = state != IDLE;
    assign bus.rsp_valid  = state == DONE;
    assign bus.rsp_result = res;
    assign bus.rsp_err    = err;
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        k_n     = k;
        res_n   = res;
        err_n   = err;
`ifdef COPROC_LCM_EN
        op_n      = op;
        ao_n      = ao;
        bo_n      = bo;
        acc_n     = acc;
        mc_n      = mc;
        div_start = 1'b0;
`endif
        case (state)
            IDLE: if (bus.req_valid) begin
                a_n   = bus.req_a;
                b_n   = bus.req_b;
                k_n   = '0;
`ifdef COPROC_LCM_EN
                op_n    = bus.req_op;
                ao_n    = bus.req_a;
                bo_n    = bus.req_b;
                acc_n   = '0;
                mc_n    = '0;
                err_n   = 1'b0;
                res_n   = bus.req_op == OP_LCM ? '0 : bus.req_a | bus.req_b;
                state_n = (bus.req_a == '0 || bus.req_b == '0) ? DONE : GCD_SHIFT;
`else
                err_n   = bus.req_op == OP_LCM;
                res_n   = err_n ? '0 : bus.req_a | bus.req_b;
                state_n = (err_n || bus.req_a == '0 || bus.req_b == '0) ? DONE : GCD_SHIFT;
`endif
            end
            GCD_SHIFT: if (a[0] | b[0]) state_n = GCD_RUN;
            else begin
                a_n = a >> 1;
                b_n = b >> 1;
                k_n = k + 1'b1;
            end
            GCD_RUN: if (a == b) begin
                res_n   = g;
                state_n = DONE;
`ifdef COPROC_LCM_EN
                if (op == OP_LCM) begin
                    state_n   = DIV;
                    div_start = 1'b1;
                end
`endif
            end else if (!a[0]) a_n = a >> 1;
            else if (!b[0]) b_n = b >> 1;
            else if (a > b) a_n = a - b;
            else b_n = b - a;
`ifdef COPROC_LCM_EN
            DIV: state_n = div_done ? MUL : DIV;
            MUL: begin
                acc_n = prod;
                mc_n  = mc + 1'b1;
                if (mc == KW'(WIDTH - 1)) begin
                    state_n = DONE;
                    res_n   = prod[WIDTH-1:0];
                    err_n   = |prod[2*WIDTH-1:WIDTH];
                end
            end
`endif
            DONE: state_n = bus.rsp_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            k     <= '0;
            res   <= '0;
            err   <= 1'b0;
`ifdef COPROC_LCM_EN
            op  <= OP_GCD;
            ao  <= '0;
            bo  <= '0;
            acc <= '0;
            mc  <= '0;
`endif
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            k     <= k_n;
            res   <= res_n;
            err   <= err_n;
`ifdef COPROC_LCM_EN
            op  <= op_n;
            ao  <= ao_n;
            bo  <= bo_n;
            acc <= acc_n;
            mc  <= mc_n;
`endif
        end
    end
endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// tb_gcd_lcm_coproc: directed GCD/LCM requests checked against an arithmetic reference model.
// Expectations follow COPROC_LCM_EN the same way the design build does.
module tb_gcd_lcm_coproc;
    import coproc_pkg::*;
    localparam int W = 32;
`ifdef COPROC_LCM_EN
    localparam bit LCM = 1'b1;
`else
    localparam bit LCM = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         reset_n;
    logic         inflight;
    logic [W-1:0] exp_res;
    logic         exp_err;
    int           n_cmp = 0;
    int           n_bad = 0;

    gcd_lcm_coproc_if #(.WIDTH(W)) bus ();
    gcd_lcm_coproc #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        n_cmp++;
        if (act > lim) begin
            n_bad++;
            $display("FAIL %s: got %0d cycles, limit %0d", nm, act, lim);
        end
    endtask

    // reference: Euclid for GCD, lcm = (a/g)*b as a double-width product
    function automatic logic [W:0] model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a, y = b, t;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        if (op == OP_GCD) return {1'b0, x};
`ifdef COPROC_LCM_EN
        if (a == '0 || b == '0) return '0;
        begin
            logic [2*W-1:0] p;
            p = (2*W)'(a / x) * (2*W)'(b);
            return {|p[2*W-1:W], p[W-1:0]};
        end
`else
        return {1'b1, {W{1'b0}}};
`endif
    endfunction

    always @(negedge clk) begin
        chk("busy", bus.busy, inflight);
        chk("req_ready", bus.req_ready, !inflight);
        if (!inflight) chk("idle_rsp_valid", bus.rsp_valid, 0);
        else if (bus.rsp_valid) chk("rsp", {bus.rsp_err, bus.rsp_result}, {exp_err, exp_res});
    end

    task automatic run(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ee, input int bp, input int maxlat);
        int c;
        logic [W:0] m;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        m        = model(op, a, b);
        exp_res  = m[W-1:0];
        exp_err  = m[W];
        inflight = 1'b1;
        chk("model_pin", m, {ee, er});
        c = 1;
        @(negedge clk);
        while (!bus.rsp_valid && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk_le("latency", c, maxlat);
        chk("result", {bus.rsp_err, bus.rsp_result}, {ee, er});
        repeat (bp) @(negedge clk);
        chk("held_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        inflight      = 1'b0;
        @(negedge clk);
        chk("back_idle", {bus.req_ready, bus.rsp_valid}, 2'b10);
    endtask

    initial begin
        reset_n       = 1'b1;
        inflight      = 1'b0;
        exp_res       = '0;
        exp_err       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_GCD;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err, bus.rsp_result},
            {4'b1000, {W{1'b0}}});
        reset_n = 1'b1;
        chk("pin_gcd_1071_462", model(OP_GCD, 1071, 462), 21);
        run(OP_GCD, 48, 18, 6, 0, 0, 2*W+2);
        run(OP_LCM, 4, 6, LCM ? 12 : 0, !LCM, 0, LCM ? 4*W+2 : 1);
        run(OP_LCM, 21, 6, LCM ? 42 : 0, !LCM, 0, LCM ? 4*W+2 : 1);
        run(OP_GCD, 0, 7, 7, 0, 0, 1);
        run(OP_GCD, 0, 0, 0, 0, 0, 1);
        run(OP_LCM, 0, 7, 0, !LCM, 0, 1);
        run(OP_GCD, 1071, 462, 21, 0, 0, 2*W+2);
        run(OP_GCD, 48, 18, 6, 0, 10, 2*W+2);
        run(OP_LCM, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LCM ? 32'h2 : 0, 1, 0, LCM ? 350 : 1);
        // abort a long GCD in the middle of its subtract/shift phase
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_GCD;
        bus.req_a     = 32'hFFFF_FFFF;
        bus.req_b     = 32'h1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        exp_res       = 32'h1;
        exp_err       = 1'b0;
        inflight      = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n  = 1'b0;
        inflight = 1'b0;
        #1;
        chk("abort_outs", {bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err, bus.rsp_result},
            {4'b1000, {W{1'b0}}});
        @(negedge clk);
        reset_n = 1'b1;
        run(OP_GCD, 12, 8, 4, 0, 0, 2*W+2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
